st_packet_arbiter: RTL
======================

# st_packet_arbiter

Round-robin, packet-locked arbiter that shares one Avalon-ST sink among N Avalon-ST sources carrying WIDTH-bit beats with start-of-packet and end-of-packet framing. In the Hamming pipeline it sits directly in front of the streaming-to-memory-mapped adapter. Several encoder or decoder lanes can therefore deliver whole packets into the single MM readout point without interleaving beats. The arbiter tags each forwarded beat with its source channel number.

## Interface
- WIDTH, 8, data bits per beat
- N, 4, number of source channels (2..16)
- CW, $clog2(N), channel-index width (derived; not overridden)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- in_valid  in  N  per-channel beat valid
- in_ready  out  N  per-channel ready; at most one bit high in any cycle
- in_data  in  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_sop  in  N  per-channel start-of-packet
- in_eop  in  N  per-channel end-of-packet
- out_valid  out  1  forwarded beat valid
- out_ready  in  1  sink ready (the adapter's in_ready)
- out_data  out  WIDTH  forwarded beat
- out_sop  out  1  forwarded sop
- out_eop  out  1  forwarded eop
- out_channel  out  CW  index of the granted channel; valid whenever state is LOCKED
- busy  out  1  high while a packet is in progress (state LOCKED)

## Operation
- State machine with one-hot encoding. It has two states:
  - IDLE: no grant.
  - LOCKED: grant held by channel g.
- Registers:
  - state
  - grant g (CW bits)
  - last (CW bits): the channel that most recently completed a packet
- IDLE:
  - in_ready = 0 and out_valid = 0.
  - If any in_valid is high, select the first asserted channel searching upward from last+1 and wrapping modulo N.
  - Load g with that channel and move to LOCKED.
  - The in_sop value is not examined at selection.
- LOCKED:
  - out_valid = in_valid[g]; out_data, out_sop and out_eop come from channel g.
  - in_ready[g] = out_ready; all other in_ready bits are 0.
  - out_channel = g and busy = 1.
- A beat transfers on a cycle where out_valid && out_ready.
- A transfer with out_eop = 1 completes the packet. On that clock edge:
  - last ← g.
  - state → IDLE.
- A single-beat packet (sop and eop both set) is legal and completes in one transfer.
- Non-granted channels are not observed while LOCKED. Their valid and data may change freely without effect.
- The arbiter does not check framing. A sop arriving mid-packet on channel g is forwarded unchanged. The lock is released only by eop.
- Fairness: after channel k completes a packet, every other requesting channel is served once before k is served again.

## Timing
- Reset (reset = 0 at a rising edge):
  - state ← IDLE.
  - last ← N-1, so channel 0 has first priority after reset.
  - g ← 0.
- Output values while state is IDLE after reset:
  - in_ready = 0, out_valid = 0, busy = 0, out_channel = 0.
  - out_data, out_sop and out_eop are 0 whenever out_valid = 0.
- Reset asserted mid-packet:
  - The grant is dropped at that edge.
  - The partial packet is abandoned. No completion is generated and last is not updated.
- Arbitration latency is one cycle. A request seen in IDLE at edge t gives the grant at edge t; the first beat can transfer in cycle t+1.
- Every packet has one bubble cycle between its eop transfer and the next packet's first beat. The peak rate is therefore L/(L+1) for L-beat packets.
- The data path is combinational from channel g to the outputs. There is no added latency within a packet, and out_ready stalls pass straight to in_ready[g].
- Beat transfer and eop release occur on the same edge. In the cycle after release, in_ready is all-zero.
- If in_valid[g] drops mid-packet, out_valid drops. The grant is held indefinitely until channel g finishes with eop.

## Test plan
- Reset and priority: hold reset = 0 for 3 cycles and check that all outputs are 0. Release reset, then assert channels 1 and 3 together, each sending a 2-beat packet. Required response:
  - Channel 1 is granted first (out_channel = 1), then channel 3.
  - The beats appear in the order 0x11, 0x12, bubble, 0x31, 0x32.
- Round-robin rotation: all 4 channels request continuously with 1-beat packets of value 0xA0+k. Over 8 packets, out_channel must follow 0,1,2,3,0,1,2,3, and each beat must be followed by one idle cycle.
- No interleave under backpressure: channel 0 sends a 4-beat packet while channel 2 requests throughout, and out_ready toggles 1,0,0,1,... Required response:
  - All 4 beats of channel 0 transfer before any beat of channel 2.
  - in_ready[2] stays 0 until channel 0's eop transfer.
- Source gap: channel 1 deasserts in_valid for 5 cycles between beats 2 and 3 while channel 0 requests. Required response:
  - out_valid is 0 for those 5 cycles.
  - The grant stays on channel 1 (busy = 1, out_channel = 1).
  - Channel 0 is served only after channel 1's eop.
- Reset mid-packet: apply reset = 0 for one cycle after beat 2 of a 4-beat packet from channel 2. Required response:
  - Next cycle: state IDLE, busy = 0, in_ready = 0.
  - The next request from channels 0 and 2 together grants channel 0, because last was reset to N-1 = 3.
- Single-beat packet with a stalled sink: channel 3 presents sop = eop = 1 and data 0x5C while out_ready = 0 for 3 cycles, then out_ready = 1. Required response:
  - out_valid = 1 with data 0x5C is held stable for 4 cycles and transfers once.
  - The arbiter then returns to IDLE, and last = 3.

Source files
------------

// File: rtl/st_packet_arbiter.sv
// st_packet_arbiter
//   Round-robin, packet-locked arbiter that shares one Avalon-ST sink among
//   N Avalon-ST sources. Once a channel is granted it keeps the sink until it
//   sends an eop beat, so packets are never interleaved. Each forwarded beat
//   is tagged with its source channel on out_channel.
//
// Ports
//   clock              rising-edge clock
//   reset              synchronous, active-low
//   in_valid/in_ready  per-channel handshake (in_ready is one-hot or zero)
//   in_data            channel k at [k*WIDTH +: WIDTH]
//   in_sop/in_eop      per-channel framing
//   out_valid/ready    sink handshake
//   out_data/sop/eop   forwarded beat of the granted channel (zero when idle)
//   out_channel        index of the granted channel
//   busy               high while a packet is in progress
module st_packet_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int CW    = $clog2(N)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_sop,
  input  logic [N-1:0]         in_eop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [CW-1:0]        out_channel,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t        state;
  logic [CW-1:0] g;
  logic [CW-1:0] last;
  logic [CW-1:0] sel;
  logic          locked;

  assign locked = (state == LOCKED);

  // Rotating priority: first requester found scanning upward from last+1,
  // wrapping modulo N (N need not be a power of two). The previous winner is
  // checked last, which gives the one-serve-each fairness.
  always_comb begin
    logic          found;
    logic [CW-1:0] cand;
    int            s;
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    s     = 0;
    for (int i = 1; i <= N; i++) begin
      s    = (int'(last) + i) % N;
      cand = CW'(s);
      if (!found && in_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Combinational data path from the granted channel; beat fields are
  // forced to zero whenever nothing is being offered.
  always_comb begin
    in_ready  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    if (locked) begin
      in_ready[g] = out_ready;
      out_valid   = in_valid[g];
      if (in_valid[g]) begin
        out_data = in_data[g*WIDTH +: WIDTH];
        out_sop  = in_sop[g];
        out_eop  = in_eop[g];
      end
    end
  end

  assign out_channel = g;
  assign busy        = locked;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      g     <= '0;
      last  <= CW'(N-1);
    end else begin
      case (state)
        IDLE: begin
          if (|in_valid) begin
            g     <= sel;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          // Only an eop transfer releases the lock; sop is never examined.
          if (out_valid && out_ready && out_eop) begin
            last  <= g;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
